// File: rtl/alu_6502.sv
// 6502-style ALU with registered result and processor-status flags.
// One operation is accepted every cycle; result and flags appear one edge later.
// Decimal mode applies only to ADC/SBC and uses a nibble-wise correction.
module alu_6502 (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alu_ctrl,
  input  logic [7:0] alu_AI,
  input  logic [7:0] alu_BI,
  input  logic       alu_carry,
  input  logic       alu_DAA,
  output logic [7:0] alu_Y,
  output logic [7:0] alu_flags
);

  localparam logic [2:0] OP_ADC  = 3'b000;
  localparam logic [2:0] OP_SBC  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORA  = 3'b011;
  localparam logic [2:0] OP_EOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [7:0] y_d, y_q;
  logic [7:0] flags_d, flags_q;

  logic [8:0] bin_add, bin_sub;
  logic       v_add, v_sub;

  logic [4:0] dadd_lo, dadd_hi;
  logic       dadd_lc, dadd_c;
  logic [3:0] dadd_lo_nib, dadd_hi_nib;

  logic [4:0] dsub_lo, dsub_hi;
  logic       dsub_lb, dsub_hb;
  logic [3:0] dsub_lo_nib, dsub_hi_nib;

  logic       c_d, v_d;

  // Binary and decimal adder/subtractor paths, plus the overflow terms shared by both modes.
  always_comb begin
    bin_add = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'b0, alu_carry};
    bin_sub = {1'b0, alu_AI} + {1'b0, ~alu_BI} + {8'b0, alu_carry};
    v_add   = (alu_AI[7] == alu_BI[7]) && (bin_add[7] != alu_AI[7]);
    v_sub   = (alu_AI[7] != alu_BI[7]) && (bin_sub[7] != alu_AI[7]);

    // Decimal add: each nibble above 9 is bumped by 6 and carries into the next.
    dadd_lo     = {1'b0, alu_AI[3:0]} + {1'b0, alu_BI[3:0]} + {4'b0, alu_carry};
    dadd_lc     = (dadd_lo > 5'd9);
    dadd_lo_nib = dadd_lc ? (dadd_lo[3:0] + 4'd6) : dadd_lo[3:0];
    dadd_hi     = {1'b0, alu_AI[7:4]} + {1'b0, alu_BI[7:4]} + {4'b0, dadd_lc};
    dadd_c      = (dadd_hi > 5'd9);
    dadd_hi_nib = dadd_c ? (dadd_hi[3:0] + 4'd6) : dadd_hi[3:0];

    // Decimal subtract: a negative nibble (bit 4 set) is pulled down by 6 and borrows.
    dsub_lo     = {1'b0, alu_AI[3:0]} - {1'b0, alu_BI[3:0]} - {4'b0, ~alu_carry};
    dsub_lb     = dsub_lo[4];
    dsub_lo_nib = dsub_lb ? (dsub_lo[3:0] - 4'd6) : dsub_lo[3:0];
    dsub_hi     = {1'b0, alu_AI[7:4]} - {1'b0, alu_BI[7:4]} - {4'b0, dsub_lb};
    dsub_hb     = dsub_hi[4];
    dsub_hi_nib = dsub_hb ? (dsub_hi[3:0] - 4'd6) : dsub_hi[3:0];
  end

  // Operation select: result, carry and overflow; N/Z and the fixed bits are derived afterwards.
  always_comb begin
    y_d = alu_BI;
    c_d = alu_carry;
    v_d = 1'b0;
    case (alu_ctrl)
      OP_ADC: begin
        y_d = alu_DAA ? {dadd_hi_nib, dadd_lo_nib} : bin_add[7:0];
        c_d = alu_DAA ? dadd_c : bin_add[8];
        v_d = v_add;
      end
      OP_SBC: begin
        y_d = alu_DAA ? {dsub_hi_nib, dsub_lo_nib} : bin_sub[7:0];
        c_d = alu_DAA ? ~dsub_hb : bin_sub[8];
        v_d = v_sub;
      end
      OP_AND:  y_d = alu_AI & alu_BI;
      OP_ORA:  y_d = alu_AI | alu_BI;
      OP_EOR:  y_d = alu_AI ^ alu_BI;
      OP_SHL: begin
        y_d = {alu_AI[6:0], alu_carry};
        c_d = alu_AI[7];
      end
      OP_SHR: begin
        y_d = {alu_carry, alu_AI[7:1]};
        c_d = alu_AI[0];
      end
      OP_PASS: y_d = alu_BI;
      default: y_d = alu_BI;
    endcase
    flags_d = {y_d[7], v_d, 1'b1, 1'b0, alu_DAA, 1'b0, (y_d == 8'h00), c_d};
  end

  // Output registers; reset clears the result and leaves only the always-one status bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q     <= 8'h00;
      flags_q <= 8'h20;
    end else begin
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign alu_Y     = y_q;
  assign alu_flags = flags_q;

endmodule

// File: tb/tb_alu_6502.sv
// Directed testbench for alu_6502: a table of hand-computed vectors plus
// sequences for pipelining latency and mid-stream reset.
module tb_alu_6502;

  logic       clk;
  logic       reset;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_carry;
  logic       alu_DAA;
  logic [7:0] alu_Y;
  logic [7:0] alu_flags;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [2:0] ADC = 3'd0, SBC = 3'd1, AND_ = 3'd2, ORA = 3'd3,
                         EOR = 3'd4, SHL = 3'd5, SHR = 3'd6, PASS = 3'd7;

  typedef struct {
    string      name;
    logic [2:0] ctrl;
    logic [7:0] ai;
    logic [7:0] bi;
    logic       carry;
    logic       daa;
    logic [7:0] expY;
    logic [7:0] expFlags;
  } vec_t;

  vec_t vecs[$];

  alu_6502 dut (
    .clk       (clk),
    .reset     (reset),
    .alu_ctrl  (alu_ctrl),
    .alu_AI    (alu_AI),
    .alu_BI    (alu_BI),
    .alu_carry (alu_carry),
    .alu_DAA   (alu_DAA),
    .alu_Y     (alu_Y),
    .alu_flags (alu_flags)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operation's inputs; called away from the rising edge.
  task automatic applyStimulus(input vec_t v);
    alu_ctrl  = v.ctrl;
    alu_AI    = v.ai;
    alu_BI    = v.bi;
    alu_carry = v.carry;
    alu_DAA   = v.daa;
  endtask

  // Compare registered outputs against expected values.
  task automatic checkOutput(input string name, input logic [7:0] expY, input logic [7:0] expFlags);
    assertCount++;
    if (alu_Y !== expY) begin
      failCount++;
      $display("[TB] FAIL %s Y: got %02h expected %02h", name, alu_Y, expY);
    end
    assertCount++;
    if (alu_flags !== expFlags) begin
      failCount++;
      $display("[TB] FAIL %s flags: got %02h expected %02h", name, alu_flags, expFlags);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string n, logic [2:0] c, logic [7:0] a, logic [7:0] b,
                              logic cy, logic d, logic [7:0] y, logic [7:0] f);
    vec_t v;
    v.name = n; v.ctrl = c; v.ai = a; v.bi = b; v.carry = cy; v.daa = d;
    v.expY = y; v.expFlags = f;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("adc_50_50_ovf",   ADC,  8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hE0));
    vecs.push_back(mk("adc_ff_01_zero",  ADC,  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h23));
    vecs.push_back(mk("adc_7f_cin_ovf",  ADC,  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 8'hE0));
    vecs.push_back(mk("sbc_50_30",       SBC,  8'h50, 8'h30, 1'b1, 1'b0, 8'h20, 8'h21));
    vecs.push_back(mk("sbc_cmp_borrow",  SBC,  8'h30, 8'h50, 1'b1, 1'b0, 8'hE0, 8'hA0));
    vecs.push_back(mk("sbc_80_01_ovf",   SBC,  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 8'h61));
    vecs.push_back(mk("adc_dec_58_46",   ADC,  8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 8'h69));
    vecs.push_back(mk("adc_dec_99_01",   ADC,  8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 8'h2B));
    vecs.push_back(mk("adc_dec_nonbcd",  ADC,  8'h0F, 8'h00, 1'b0, 1'b1, 8'h15, 8'h28));
    vecs.push_back(mk("sbc_dec_12_21",   SBC,  8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 8'hA8));
    vecs.push_back(mk("sbc_dec_00_01",   SBC,  8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 8'hA8));
    vecs.push_back(mk("and_f0_3c",       AND_, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 8'h21));
    vecs.push_back(mk("ora_80_01",       ORA,  8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 8'hA0));
    vecs.push_back(mk("eor_zero_daa",    EOR,  8'hAA, 8'hAA, 1'b1, 1'b1, 8'h00, 8'h2B));
    vecs.push_back(mk("shr_lsr_01",      SHR,  8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h23));
    vecs.push_back(mk("shr_ror_02",      SHR,  8'h02, 8'h00, 1'b1, 1'b0, 8'h81, 8'hA0));
    vecs.push_back(mk("shl_rol_80",      SHL,  8'h80, 8'h00, 1'b1, 1'b0, 8'h01, 8'h21));
    vecs.push_back(mk("shl_asl_40",      SHL,  8'h40, 8'h00, 1'b0, 1'b0, 8'h80, 8'hA0));
    vecs.push_back(mk("pass_7f",         PASS, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h7F, 8'h20));

    // Reset with busy inputs must still clear the outputs.
    reset = 1'b1;
    applyStimulus(vecs[0]);
    stepEdge();
    stepEdge();
    checkOutput("reset_state", 8'h00, 8'h20);
    reset = 1'b0;

    // Table-driven single operations.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      stepEdge();
      checkOutput(vecs[i].name, vecs[i].expY, vecs[i].expFlags);
    end

    // Back-to-back: new inputs must not show before the edge, and must show right after it.
    applyStimulus(vecs[0]);
    stepEdge();
    checkOutput("b2b_first", 8'hA0, 8'hE0);
    applyStimulus(vecs[9]);
    #2;
    checkOutput("b2b_hold_before_edge", 8'hA0, 8'hE0);
    stepEdge();
    checkOutput("b2b_second", 8'h91, 8'hA8);
    applyStimulus(vecs[16]);
    stepEdge();
    checkOutput("b2b_third", 8'h01, 8'h21);

    // Reset for one edge mid-stream discards the op, next edge registers the new op.
    applyStimulus(vecs[1]);
    reset = 1'b1;
    stepEdge();
    checkOutput("midreset_cleared", 8'h00, 8'h20);
    reset = 1'b0;
    applyStimulus(vecs[6]);
    stepEdge();
    checkOutput("after_reset_op", 8'h05, 8'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
